// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer: sel/enable/anode generator for the 4:1 display mux.
// Scan, manual step, hold or off, with output blanking around every sel change.
module mux_select_sequencer #(
    parameter int TICK_DIV        = 100000,
    parameter int BLANK_CYCLES    = 16,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       step_btn,
    output logic [1:0] sel,
    output logic [3:0] enable,
    output logic [3:0] an,
    output logic       slot_tick
);

    localparam int PW = $clog2(TICK_DIV) + 1;
    localparam int BW = $clog2(BLANK_CYCLES) + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic [BW-1:0] blank;
    logic [BW-1:0] blank_nxt;
    logic [1:0]    sel_nxt;
    logic [3:0]    an_nxt;
    logic          advance;
    logic          drive;
    logic          is_off;
    logic          is_scan;
    logic          is_step;
    logic          is_hold;

    logic          sync1;
    logic          sync2;
    logic          deb;
    logic          deb_q;
    logic          step_evt;
    logic [DW-1:0] deb_cnt;

    always_comb begin
        state_nxt = ST_OFF;
        unique case (mode)
            2'b00: state_nxt = ST_OFF;
            2'b01: state_nxt = ST_SCAN;
            2'b10: state_nxt = ST_STEP;
            2'b11: state_nxt = ST_HOLD;
            default: state_nxt = ST_OFF;
        endcase
    end

    assign is_off  = (state == ST_OFF);
    assign is_scan = (state == ST_SCAN);
    assign is_step = (state == ST_STEP);
    assign is_hold = (state == ST_HOLD);

    // The current state picks this cycle's action; a new mode acts one cycle later.
    always_comb begin
        presc_nxt = presc;
        advance   = 1'b0;
        unique case (1'b1)
            is_scan: begin
                if (presc == PRESC_LAST) begin
                    presc_nxt = '0;
                    advance   = 1'b1;
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            is_step: advance = step_evt;
            is_hold: presc_nxt = presc;
            is_off:  presc_nxt = presc;
            default: presc_nxt = presc;
        endcase
        if (!is_scan && state_nxt == ST_SCAN) begin
            presc_nxt = '0;
        end
    end

    always_comb begin
        sel_nxt   = advance ? sel + 2'd1 : sel;
        blank_nxt = '0;
        if (advance) begin
            blank_nxt = BLANK_LOAD;
        end else if (blank != '0) begin
            blank_nxt = blank - BW'(1);
        end
        drive  = !is_off && (blank_nxt == '0);
        an_nxt = drive ? ~(4'b0001 << sel_nxt) : 4'hF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_OFF;
            presc     <= '0;
            blank     <= '0;
            sel       <= '0;
            enable    <= 4'h0;
            an        <= 4'hF;
            slot_tick <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            blank     <= blank_nxt;
            sel       <= sel_nxt;
            enable    <= drive ? 4'hF : 4'h0;
            an        <= an_nxt;
            slot_tick <= advance;
        end
    end

    // Debounce runs in every state; its rising edge is registered once more as the step event.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            deb      <= 1'b0;
            deb_q    <= 1'b0;
            deb_cnt  <= '0;
            step_evt <= 1'b0;
        end else begin
            sync1    <= step_btn;
            sync2    <= sync1;
            deb_q    <= deb;
            step_evt <= deb & ~deb_q;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

endmodule
